// File: rtl/vend_output_ctrl.sv
// Sale-event FIFO: holds {drink, back} entries between the vending FSM and the actuator sequencer.
// Latency: an entry pushed at one edge is at the head from the next edge onward.
// Backpressure: a push while full is accepted only when a pop happens at the same edge.
module vend_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    input  logic         pop_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign pop_vld  = (count != '0);
    assign do_pop   = pop_rdy && pop_vld;
    assign push_rdy = (count != FULL_CNT) || do_pop;
    assign do_push  = push_vld && push_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Actuator sequencer: runs the dispense motor, then ejects change coins over a four-phase req/ack handshake.
// Latency: an event sampled at edge T is popped at T+1 at the earliest; motor/req are registered from the pop edge.
// Backpressure: none toward the vending FSM; events arriving while the queue is full are dropped and flagged.
module vend_output_ctrl #(
    parameter int DEPTH        = 4,
    parameter int MOTOR_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       drink,
    input  logic [1:0] back,
    output logic       coin_eject_req,
    input  logic       coin_eject_ack,
    output logic       dispense_motor,
    output logic       busy,
    output logic       overflow,
    output logic       fault,
    output logic [7:0] dispensed_cnt
);
    localparam int MW = $clog2(MOTOR_CYCLES + 1);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [MW-1:0] MOTOR_LOAD = MW'(MOTOR_CYCLES);
    localparam logic [TW-1:0] TMR_LAST   = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MOTOR, REQ, RELEASE} state_t;

    state_t        state;
    logic [MW-1:0] motor_cnt;
    logic [TW-1:0] ack_tmr;
    logic [1:0]    left;

    logic       evt_vld;
    logic [2:0] evt_dat;
    logic       evt_rdy;
    logic       head_vld;
    logic [2:0] head_dat;
    logic       pop_rdy;

    assign evt_vld = drink || (back != 2'd0);
    assign evt_dat = {drink, back};
    assign pop_rdy = (state == IDLE);
    assign busy    = head_vld || (state != IDLE);

    vend_fifo #(.W(3), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (evt_vld),
        .push_dat (evt_dat),
        .push_rdy (evt_rdy),
        .pop_rdy  (pop_rdy),
        .pop_vld  (head_vld),
        .pop_dat  (head_dat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            motor_cnt      <= '0;
            ack_tmr        <= '0;
            left           <= 2'd0;
            dispense_motor <= 1'b0;
            coin_eject_req <= 1'b0;
            overflow       <= 1'b0;
            fault          <= 1'b0;
            dispensed_cnt  <= 8'd0;
        end else begin
            if (evt_vld && !evt_rdy) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (head_vld) begin
                        left    <= head_dat[1:0];
                        ack_tmr <= '0;
                        if (head_dat[2]) begin
                            state          <= MOTOR;
                            dispense_motor <= 1'b1;
                            motor_cnt      <= MOTOR_LOAD;
                        end else if (head_dat[1:0] != 2'd0) begin
                            // An ejector still holding ack cannot be handshaken with; give up on this change.
                            if (coin_eject_ack) begin
                                fault <= 1'b1;
                                left  <= 2'd0;
                            end else begin
                                state          <= REQ;
                                coin_eject_req <= 1'b1;
                            end
                        end
                    end
                end
                MOTOR: begin
                    if (motor_cnt == MW'(1)) begin
                        dispense_motor <= 1'b0;
                        dispensed_cnt  <= dispensed_cnt + 8'd1;
                        ack_tmr        <= '0;
                        if (left != 2'd0 && !coin_eject_ack) begin
                            state          <= REQ;
                            coin_eject_req <= 1'b1;
                        end else begin
                            if (left != 2'd0) begin
                                fault <= 1'b1;
                            end
                            left  <= 2'd0;
                            state <= IDLE;
                        end
                    end else begin
                        motor_cnt <= motor_cnt - 1'b1;
                    end
                end
                REQ: begin
                    if (coin_eject_ack) begin
                        coin_eject_req <= 1'b0;
                        ack_tmr        <= '0;
                        state          <= RELEASE;
                    end else if (ack_tmr == TMR_LAST) begin
                        coin_eject_req <= 1'b0;
                        fault          <= 1'b1;
                        left           <= 2'd0;
                        state          <= IDLE;
                    end else begin
                        ack_tmr <= ack_tmr + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!coin_eject_ack) begin
                        left    <= left - 2'd1;
                        ack_tmr <= '0;
                        if (left == 2'd1) begin
                            state <= IDLE;
                        end else begin
                            state          <= REQ;
                            coin_eject_req <= 1'b1;
                        end
                    end else if (ack_tmr == TMR_LAST) begin
                        fault <= 1'b1;
                        left  <= 2'd0;
                        state <= IDLE;
                    end else begin
                        ack_tmr <= ack_tmr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vend_output_ctrl.sv
// Bench for vend_output_ctrl: directed scenarios plus randomized bursts scored against a token-level model
// (each accepted entry contributes one motor run if it carries a drink, then one coin per half-unit owed).
module tb_vend_output_ctrl;
    localparam int DEPTH        = 4;
    localparam int MOTOR_CYCLES = 8;
    localparam int ACK_TIMEOUT  = 16;
    localparam int TOK_M = 1;
    localparam int TOK_C = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       drink = 1'b0;
    logic [1:0] back = 2'd0;
    logic       coin_eject_ack = 1'b0;
    logic       coin_eject_req;
    logic       dispense_motor;
    logic       busy;
    logic       overflow;
    logic       fault;
    logic [7:0] dispensed_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int ej_mode = 0;
    int ej_dly  = 2;
    int ej_cnt  = 0;

    int obs[$];
    int exp_q[$];
    int bad_len = 0;
    int req_in_motor = 0;
    int last_req_len = 0;
    int req_run = 0;
    int mot_run = 0;
    logic prev_m = 1'b0;
    logic prev_r = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    vend_output_ctrl #(
        .DEPTH(DEPTH), .MOTOR_CYCLES(MOTOR_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .drink          (drink),
        .back           (back),
        .coin_eject_req (coin_eject_req),
        .coin_eject_ack (coin_eject_ack),
        .dispense_motor (dispense_motor),
        .busy           (busy),
        .overflow       (overflow),
        .fault          (fault),
        .dispensed_cnt  (dispensed_cnt)
    );

    always #5 clk = ~clk;

    // Ejector: 0 = ack tied low, 1 = follows req after ej_dly cycles, 2 = ack stuck high.
    always @(negedge clk) begin
        case (ej_mode)
            0: begin coin_eject_ack = 1'b0; ej_cnt = 0; end
            2: begin coin_eject_ack = 1'b1; ej_cnt = 0; end
            default: begin
                if (coin_eject_req != coin_eject_ack) begin
                    ej_cnt++;
                    if (ej_cnt >= ej_dly) begin
                        coin_eject_ack = coin_eject_req;
                        ej_cnt = 0;
                    end
                end else begin
                    ej_cnt = 0;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            mot_run = 0; req_run = 0; prev_m = 1'b0; prev_r = 1'b0;
        end else begin
            if (dispense_motor) begin
                mot_run++;
            end else if (prev_m) begin
                obs.push_back(TOK_M);
                if (mot_run != MOTOR_CYCLES) bad_len++;
                mot_run = 0;
            end
            if (coin_eject_req) begin
                if (!prev_r) obs.push_back(TOK_C);
                if (dispense_motor) req_in_motor++;
                req_run++;
            end else if (prev_r) begin
                last_req_len = req_run;
                req_run = 0;
            end
            prev_m = dispense_motor;
            prev_r = coin_eject_req;
        end
    end

    function automatic bit tokens_match();
        if (obs.size() != exp_q.size()) return 1'b0;
        foreach (obs[i]) if (obs[i] != exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic add_exp(input logic d, input logic [1:0] b);
        if (d) begin
            exp_q.push_back(TOK_M);
            exp_cnt = exp_cnt + 8'd1;
        end
        for (int k = 0; k < int'(b); k++) exp_q.push_back(TOK_C);
    endtask

    task automatic send(input logic d, input logic [1:0] b);
        drink = d; back = b;
        @(negedge clk);
        drink = 1'b0; back = 2'd0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < 3000) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", nm, busy, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; drink = 1'b0; back = 2'd0; ej_mode = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dispense_motor !== 1'b0) begin n_bad++; $display("FAIL reset_motor: got %b want 0", dispense_motor); end
        n_cmp++; if (coin_eject_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", coin_eject_req); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
        n_cmp++; if (dispensed_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", dispensed_cnt); end
        reset = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
    endtask

    task automatic test_single_sale();
        logic exp_m;
        obs.delete(); exp_q.delete(); ej_mode = 0;
        add_exp(1'b1, 2'd0);
        send(1'b1, 2'd0);
        // Event held during cycle 0; motor must be high for cycles 2..9.
        for (int c = 1; c <= 12; c++) begin
            exp_m = (c >= 2 && c <= 9);
            n_cmp++;
            if (dispense_motor !== exp_m) begin
                n_bad++;
                $display("FAIL single_motor_c%0d: got %b want %b", c, dispense_motor, exp_m);
            end
            @(negedge clk);
        end
        wait_idle("single");
        n_cmp++; if (dispensed_cnt !== exp_cnt) begin n_bad++; $display("FAIL single_cnt: got %0d want %0d", dispensed_cnt, exp_cnt); end
        n_cmp++; if (!tokens_match()) begin n_bad++; $display("FAIL single_tokens: got %0d tokens want %0d (no req)", obs.size(), exp_q.size()); end
    endtask

    task automatic test_sale_change();
        obs.delete(); exp_q.delete(); ej_mode = 1; ej_dly = 2;
        add_exp(1'b1, 2'd2);
        send(1'b1, 2'd2);
        wait_idle("change");
        n_cmp++; if (!tokens_match()) begin n_bad++; $display("FAIL change_tokens: got %0d tokens want %0d", obs.size(), exp_q.size()); end
        n_cmp++; if (dispensed_cnt !== exp_cnt) begin n_bad++; $display("FAIL change_cnt: got %0d want %0d", dispensed_cnt, exp_cnt); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL change_fault: got %b want 0", fault); end
        n_cmp++; if (req_in_motor !== 0) begin n_bad++; $display("FAIL change_overlap: req during motor %0d cycles, want 0", req_in_motor); end
    endtask

    task automatic test_change_only();
        obs.delete(); exp_q.delete(); ej_mode = 1; ej_dly = 2;
        add_exp(1'b0, 2'd3);
        send(1'b0, 2'd3);
        wait_idle("chgonly");
        n_cmp++; if (!tokens_match()) begin n_bad++; $display("FAIL chgonly_tokens: got %0d tokens want %0d", obs.size(), exp_q.size()); end
        n_cmp++; if (dispensed_cnt !== exp_cnt) begin n_bad++; $display("FAIL chgonly_cnt: got %0d want %0d", dispensed_cnt, exp_cnt); end
    endtask

    task automatic test_burst();
        obs.delete(); exp_q.delete(); ej_mode = 1; ej_dly = 2;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL burst_pre_overflow: got %b want 0", overflow); end
        // Six back-to-back events: one pops mid-burst, four fill the queue, the sixth is dropped.
        for (int i = 0; i < 5; i++) add_exp(1'b1, 2'd1);
        drink = 1'b1; back = 2'd1;
        repeat (6) @(negedge clk);
        drink = 1'b0; back = 2'd0;
        wait_idle("burst");
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL burst_overflow: got %b want 1", overflow); end
        n_cmp++; if (dispensed_cnt !== exp_cnt) begin n_bad++; $display("FAIL burst_cnt: got %0d want %0d", dispensed_cnt, exp_cnt); end
        n_cmp++; if (!tokens_match()) begin n_bad++; $display("FAIL burst_tokens: got %0d tokens want %0d", obs.size(), exp_q.size()); end
        n_cmp++; if (bad_len !== 0) begin n_bad++; $display("FAIL burst_motor_len: %0d runs of wrong length, want 0", bad_len); end
    endtask

    task automatic test_timeout();
        obs.delete(); exp_q.delete(); ej_mode = 0;
        send(1'b0, 2'd2);
        wait_idle("timeout");
        n_cmp++; if (last_req_len !== ACK_TIMEOUT) begin n_bad++; $display("FAIL timeout_req_len: got %0d want %0d", last_req_len, ACK_TIMEOUT); end
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL timeout_fault: got %b want 1", fault); end
        n_cmp++; if (obs.size() !== 1) begin n_bad++; $display("FAIL timeout_reqs: got %0d req pulses want 1", obs.size()); end
        ej_mode = 1;
        add_exp(1'b1, 2'd0);
        send(1'b1, 2'd0);
        wait_idle("timeout_after");
        n_cmp++; if (dispensed_cnt !== exp_cnt) begin n_bad++; $display("FAIL timeout_next_cnt: got %0d want %0d", dispensed_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid_motor();
        int act = 0;
        drink = 1'b1; back = 2'd0;
        repeat (3) @(negedge clk);
        drink = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (dispense_motor !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_motor: got %b want 1", dispense_motor); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (dispense_motor !== 1'b0) begin n_bad++; $display("FAIL rstmid_motor: got %b want 0", dispense_motor); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (dispensed_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want 0", dispensed_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rstmid_fault: got %b want 0", fault); end
        reset = 1'b0;
        exp_cnt = 8'd0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (dispense_motor || coin_eject_req || busy) act++;
        end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL rstmid_activity: %0d active cycles want 0", act); end
    endtask

    task automatic test_protocol();
        obs.delete(); exp_q.delete(); ej_mode = 2;
        repeat (2) @(negedge clk);
        send(1'b0, 2'd1);
        wait_idle("proto");
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL proto_fault: got %b want 1", fault); end
        n_cmp++; if (obs.size() !== 0) begin n_bad++; $display("FAIL proto_req: got %0d req pulses want 0", obs.size()); end
        ej_mode = 1; ej_dly = 1;
        repeat (4) @(negedge clk);
        add_exp(1'b1, 2'd1);
        send(1'b1, 2'd1);
        wait_idle("proto_after");
        n_cmp++; if (!tokens_match()) begin n_bad++; $display("FAIL proto_after_tokens: got %0d tokens want %0d", obs.size(), exp_q.size()); end
        n_cmp++; if (dispensed_cnt !== exp_cnt) begin n_bad++; $display("FAIL proto_after_cnt: got %0d want %0d", dispensed_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        logic d;
        logic [1:0] b;
        int n;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_cnt = 8'd0;
        obs.delete(); exp_q.delete(); bad_len = 0; req_in_motor = 0;
        ej_mode = 1;
        for (int burst = 0; burst < 12; burst++) begin
            ej_dly = $urandom_range(1, 4);
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                do begin
                    d = 1'($urandom_range(0, 1));
                    b = 2'($urandom_range(0, 3));
                end while (!d && b == 2'd0);
                add_exp(d, b);
                send(d, b);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle("rand");
            n_cmp++; if (dispensed_cnt !== exp_cnt) begin n_bad++; $display("FAIL rand_cnt_b%0d: got %0d want %0d", burst, dispensed_cnt, exp_cnt); end
        end
        n_cmp++; if (!tokens_match()) begin n_bad++; $display("FAIL rand_tokens: got %0d tokens want %0d", obs.size(), exp_q.size()); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rand_overflow: got %b want 0", overflow); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rand_fault: got %b want 0", fault); end
        n_cmp++; if (bad_len !== 0) begin n_bad++; $display("FAIL rand_motor_len: %0d runs of wrong length, want 0", bad_len); end
        n_cmp++; if (req_in_motor !== 0) begin n_bad++; $display("FAIL rand_overlap: req during motor %0d cycles, want 0", req_in_motor); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_sale();
        test_sale_change();
        test_change_only();
        test_burst();
        test_timeout();
        test_reset_mid_motor();
        test_protocol();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
